tap_line_buffer: RTL and testbench
==================================

Name: tap_line_buffer

Overview:
Parametrised successor to the strobe-driven tap shift line. It shifts BITS_PER_TAP samples into a TOTAL_TAPS-deep tap vector that feeds the wavelet filter bank. Shifting is either gated by an input valid or paced by a programmable internal strobe divider. It adds a fill/valid state machine, freeze, flush and a synchronous reset.

Parameters:
TOTAL_TAPS, 9, number of taps (>=1)
BITS_PER_TAP, 8, width of one sample/tap
TOTAL_BITS, TOTAL_TAPS*BITS_PER_TAP, width of o_taps; must equal the product
COUNTER_WIDTH, 25, width of strobe divider counter and i_divider
FILL_WIDTH, 4, width of o_fill_count; must hold the value TOTAL_TAPS

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high
i_value  input  BITS_PER_TAP  incoming sample
i_valid  input  1  sample qualifier (valid mode)
i_use_strobe  input  1  1 = shift on internal tick; 0 = shift on i_valid
i_divider  input  COUNTER_WIDTH  tick period minus 1
i_freeze  input  1  hold taps/fill/state
i_flush  input  1  clear taps and return to EMPTY
o_taps  output  TOTAL_BITS  tap k = o_taps[k*BITS_PER_TAP +: BITS_PER_TAP]; k=0 newest
o_taps_valid  output  1  high while state is FULL
o_shift_stb  output  1  one-cycle pulse in the cycle o_taps shows a new sample
o_fill_count  output  FILL_WIDTH  samples held, saturates at TOTAL_TAPS
o_state  output  2  0 EMPTY, 1 FILLING, 2 FULL
o_LED  output  1  heartbeat = !counter[COUNTER_WIDTH-1]

Behaviour:
- Reset (synchronous, highest priority): all outputs 0 except o_LED=1. counter=0, state EMPTY.
- Divider: tick = (counter >= i_divider), combinational. On tick, counter <= 0; else counter <= counter+1. The counter runs regardless of freeze and flush.
- i_divider=0 gives a tick every cycle. Lowering i_divider below the current counter wraps the counter on the next edge; there is no long run-out.
- shift_en = !i_flush && !i_freeze && (i_use_strobe ? tick : i_valid). In strobe mode i_valid is ignored.
- On shift_en: o_taps <= {o_taps[TOTAL_BITS-BITS_PER_TAP-1:0], i_value}. When TOTAL_TAPS=1, o_taps <= i_value.
- Latency is 1 cycle: i_value sampled at edge N appears at tap 0 after edge N. o_shift_stb is registered from shift_en, so it is aligned with that o_taps update.
- On shift_en, o_fill_count <= min(o_fill_count+1, TOTAL_TAPS).
- EMPTY -> FILLING on shift_en. If TOTAL_TAPS=1, EMPTY -> FULL directly.
- FILLING -> FULL on the shift_en that brings the fill count to TOTAL_TAPS.
- FULL stays FULL. Further shifts keep sliding the window.
- o_taps_valid = (state==FULL), registered. It rises in the same cycle as the fill-completing o_shift_stb.
- Flush: o_taps<=0, fill<=0, state<=EMPTY, o_taps_valid<=0, o_shift_stb<=0. Flush beats freeze and shift in the same cycle; the sample is dropped.
- Freeze: o_taps, fill and state hold; o_shift_stb=0; ticks occurring during freeze are lost, not queued.
- Unreachable state 3 returns to EMPTY on the next edge with taps cleared.
- Reset mid-fill or mid-FULL: next cycle matches post-reset values exactly.

Test Plan:
1. Reset, valid mode, i_valid=1 with i_value=1..9 on consecutive cycles -> fill 1..9; after 9th edge tap0=9 ... tap8=1, o_taps_valid=1, o_state=2, o_shift_stb high 9 cycles.
2. Strobe mode, i_divider=3, i_value=cycle count -> o_shift_stb every 4th cycle; captured values 3,7,11,... (first tick at counter==3). i_valid toggling has no effect.
3. Valid mode, fill 4 samples, i_freeze=1 for 5 cycles with i_valid=1 -> o_taps, fill=4, state FILLING unchanged; no o_shift_stb.
4. FULL, same-cycle i_flush=1 and i_valid=1 (i_value=0xAA) -> next cycle o_taps=0, fill=0, EMPTY, valid=0; 0xAA is not captured.
5. Strobe mode, i_divider=1000, counter reaches 500, then i_divider=10 -> tick on next edge, then every 11 cycles.
6. FULL with nonzero taps, assert reset for 1 cycle -> all outputs 0, o_LED=1, counter 0; the refill then behaves as in scenario 1.

Source files
------------

// File: rtl/tap_line_buffer.sv
// Tap shift line: shifts samples into a TOTAL_TAPS-deep window, gated by i_valid or by an
// internal strobe divider, with fill tracking, freeze and flush.
module tap_line_buffer #(
  parameter int unsigned TOTAL_TAPS    = 9,
  parameter int unsigned BITS_PER_TAP  = 8,
  parameter int unsigned TOTAL_BITS    = TOTAL_TAPS * BITS_PER_TAP,
  parameter int unsigned COUNTER_WIDTH = 25,
  parameter int unsigned FILL_WIDTH    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [BITS_PER_TAP-1:0]  i_value,
  input  logic                     i_valid,
  input  logic                     i_use_strobe,
  input  logic [COUNTER_WIDTH-1:0] i_divider,
  input  logic                     i_freeze,
  input  logic                     i_flush,
  output logic [TOTAL_BITS-1:0]    o_taps,
  output logic                     o_taps_valid,
  output logic                     o_shift_stb,
  output logic [FILL_WIDTH-1:0]    o_fill_count,
  output logic [1:0]               o_state,
  output logic                     o_LED
);

  typedef enum logic [1:0] {
    StEmpty   = 2'd0,
    StFilling = 2'd1,
    StFull    = 2'd2,
    StInvalid = 2'd3
  } state_e;

  localparam logic [FILL_WIDTH-1:0] TapsMax = FILL_WIDTH'(TOTAL_TAPS);

  logic [COUNTER_WIDTH-1:0] counter_q, counter_d;
  logic [TOTAL_BITS-1:0]    taps_q, taps_d, taps_shifted;
  logic [FILL_WIDTH-1:0]    fill_q, fill_d, fill_inc;
  state_e                   state_q, state_d;
  logic                     valid_q, valid_d;
  logic                     stb_q, stb_d;
  logic                     tick;
  logic                     shift_en;

  // Divider runs independently of freeze/flush; lowering i_divider wraps on the next edge.
  assign tick      = (counter_q >= i_divider);
  assign counter_d = tick ? '0 : counter_q + COUNTER_WIDTH'(1);

  assign shift_en = !i_flush && !i_freeze && (i_use_strobe ? tick : i_valid);

  if (TOTAL_TAPS == 1) begin : gen_single
    assign taps_shifted = i_value;
  end else begin : gen_multi
    assign taps_shifted = {taps_q[TOTAL_BITS-BITS_PER_TAP-1:0], i_value};
  end

  always_comb begin
    taps_d   = taps_q;
    fill_d   = fill_q;
    state_d  = state_q;
    stb_d    = 1'b0;
    fill_inc = (fill_q >= TapsMax) ? TapsMax : fill_q + FILL_WIDTH'(1);
    if (i_flush || state_q == StInvalid) begin
      taps_d  = '0;
      fill_d  = '0;
      state_d = StEmpty;
    end else if (shift_en) begin
      taps_d  = taps_shifted;
      fill_d  = fill_inc;
      state_d = (fill_inc == TapsMax) ? StFull : StFilling;
      stb_d   = 1'b1;
    end
    valid_d = (state_d == StFull);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      counter_q <= '0;
      taps_q    <= '0;
      fill_q    <= '0;
      state_q   <= StEmpty;
      valid_q   <= 1'b0;
      stb_q     <= 1'b0;
    end else begin
      counter_q <= counter_d;
      taps_q    <= taps_d;
      fill_q    <= fill_d;
      state_q   <= state_d;
      valid_q   <= valid_d;
      stb_q     <= stb_d;
    end
  end

  assign o_taps       = taps_q;
  assign o_taps_valid = valid_q;
  assign o_shift_stb  = stb_q;
  assign o_fill_count = fill_q;
  assign o_state      = state_q;
  assign o_LED        = ~counter_q[COUNTER_WIDTH-1];

endmodule

// File: tb/tb_tap_line_buffer.sv
// Randomized and directed bench for tap_line_buffer against a sample-window reference model.
module tb_tap_line_buffer;

  localparam int unsigned Taps  = 9;
  localparam int unsigned Bits  = 8;
  localparam int unsigned Total = Taps * Bits;
  localparam int unsigned CntW  = 25;
  localparam int unsigned FillW = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [Bits-1:0]  i_value = '0;
  logic             i_valid = 1'b0;
  logic             i_use_strobe = 1'b0;
  logic [CntW-1:0]  i_divider = '0;
  logic             i_freeze = 1'b0;
  logic             i_flush = 1'b0;
  logic [Total-1:0] o_taps;
  logic             o_taps_valid;
  logic             o_shift_stb;
  logic [FillW-1:0] o_fill_count;
  logic [1:0]       o_state;
  logic             o_LED;

  tap_line_buffer dut (
    .clk          (clk),
    .reset        (reset),
    .i_value      (i_value),
    .i_valid      (i_valid),
    .i_use_strobe (i_use_strobe),
    .i_divider    (i_divider),
    .i_freeze     (i_freeze),
    .i_flush      (i_flush),
    .o_taps       (o_taps),
    .o_taps_valid (o_taps_valid),
    .o_shift_stb  (o_shift_stb),
    .o_fill_count (o_fill_count),
    .o_state      (o_state),
    .o_LED        (o_LED)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a sample window, a fill count and a free-running divider counter.
  int unsigned     cnt_m  = 0;
  int unsigned     fill_m = 0;
  logic [Bits-1:0] win_m[Taps];
  bit              stb_m  = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [Total-1:0] pack_window();
    logic [Total-1:0] v;
    v = '0;
    for (int k = 0; k < Taps; k++) v[k*Bits +: Bits] = win_m[k];
    return v;
  endfunction

  function automatic logic [1:0] state_of(input int unsigned f);
    if (f == 0) return 2'd0;
    if (f == Taps) return 2'd2;
    return 2'd1;
  endfunction

  // Advance model with current inputs, clock the DUT, then compare every output.
  task automatic step();
    bit tick, sh;
    if (reset) begin
      cnt_m  = 0;
      fill_m = 0;
      stb_m  = 0;
      for (int k = 0; k < Taps; k++) win_m[k] = '0;
    end else begin
      tick  = (cnt_m >= i_divider);
      cnt_m = tick ? 0 : cnt_m + 1;
      sh    = !i_flush && !i_freeze && (i_use_strobe ? tick : i_valid);
      stb_m = sh;
      if (i_flush) begin
        fill_m = 0;
        for (int k = 0; k < Taps; k++) win_m[k] = '0;
      end else if (sh) begin
        for (int k = Taps - 1; k > 0; k--) win_m[k] = win_m[k-1];
        win_m[0] = i_value;
        if (fill_m < Taps) fill_m++;
      end
    end
    @(posedge clk);
    #1;
    check("taps", o_taps, pack_window());
    check("valid", o_taps_valid, fill_m == Taps);
    check("stb", o_shift_stb, stb_m);
    check("fill", o_fill_count, fill_m);
    check("state", o_state, state_of(fill_m));
    check("led", o_LED, ((cnt_m >> (CntW - 1)) & 1) == 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    int stb_count;
    logic [Total-1:0] saved;

    for (int k = 0; k < Taps; k++) win_m[k] = '0;
    do_reset();
    check("rst_taps", o_taps, '0);
    check("rst_led", o_LED, 1'b1);

    // Scenario 1: valid-mode fill with 1..9
    i_use_strobe = 1'b0;
    i_valid      = 1'b1;
    stb_count    = 0;
    for (int v = 1; v <= 9; v++) begin
      i_value = 8'(v);
      step();
      check("s1_fill", o_fill_count, v);
      if (o_shift_stb) stb_count++;
    end
    i_valid = 1'b0;
    check("s1_taps", o_taps, 72'h01_02_03_04_05_06_07_08_09);
    check("s1_valid", o_taps_valid, 1'b1);
    check("s1_state", o_state, 2'd2);
    check("s1_stb_count", stb_count, 9);

    // Scenario 2: strobe mode, divider 3, i_valid noise ignored
    do_reset();
    i_use_strobe = 1'b1;
    i_divider    = 3;
    stb_count    = 0;
    for (int c = 0; c < 24; c++) begin
      i_value = 8'(c);
      i_valid = 1'($urandom);
      step();
      if (o_shift_stb) stb_count++;
    end
    check("s2_stb_count", stb_count, 6);
    check("s2_tap0", o_taps[7:0], 8'd23);
    check("s2_tap1", o_taps[15:8], 8'd19);

    // Scenario 3: freeze holds a partial fill
    do_reset();
    i_use_strobe = 1'b0;
    i_valid      = 1'b1;
    for (int i = 0; i < 4; i++) begin
      i_value = 8'($urandom);
      step();
    end
    saved    = o_taps;
    i_freeze = 1'b1;
    for (int i = 0; i < 5; i++) begin
      i_value = 8'($urandom);
      step();
      check("s3_stb", o_shift_stb, 1'b0);
      check("s3_taps", o_taps, saved);
      check("s3_fill", o_fill_count, 4);
      check("s3_state", o_state, 2'd1);
    end
    i_freeze = 1'b0;

    // Scenario 4: flush beats a same-cycle valid sample
    do_reset();
    for (int i = 0; i < 9; i++) begin
      i_value = 8'($urandom_range(1, 255));
      step();
    end
    check("s4_full", o_state, 2'd2);
    i_flush = 1'b1;
    i_value = 8'hAA;
    step();
    i_flush = 1'b0;
    i_valid = 1'b0;
    check("s4_taps", o_taps, '0);
    check("s4_fill", o_fill_count, 0);
    check("s4_state", o_state, 2'd0);
    check("s4_valid", o_taps_valid, 1'b0);

    // Scenario 5: lowering the divider below the running count wraps immediately
    do_reset();
    i_use_strobe = 1'b1;
    i_divider    = 1000;
    for (int i = 0; i < 500; i++) begin
      i_value = 8'(i);
      step();
    end
    check("s5_no_tick_yet", o_fill_count, 0);
    i_divider = 10;
    step();
    check("s5_tick", o_shift_stb, 1'b1);
    for (int i = 0; i < 33; i++) begin
      i_value = 8'($urandom);
      step();
      check("s5_period", o_shift_stb, (i % 11) == 10);
    end

    // Scenario 6: reset while FULL, then refill
    do_reset();
    i_use_strobe = 1'b0;
    i_valid      = 1'b1;
    for (int i = 0; i < 9; i++) begin
      i_value = 8'($urandom) | 8'h01;
      step();
    end
    do_reset();
    check("s6_taps", o_taps, '0);
    check("s6_valid", o_taps_valid, 1'b0);
    check("s6_stb", o_shift_stb, 1'b0);
    check("s6_fill", o_fill_count, 0);
    check("s6_state", o_state, 2'd0);
    check("s6_led", o_LED, 1'b1);
    for (int v = 1; v <= 9; v++) begin
      i_value = 8'(v);
      step();
    end
    i_valid = 1'b0;
    check("s6_refill", o_taps, 72'h01_02_03_04_05_06_07_08_09);
    check("s6_refill_state", o_state, 2'd2);

    // Random mix of modes, freeze, flush and reset
    for (int i = 0; i < 1500; i++) begin
      if (i % 200 == 0) i_use_strobe = ~i_use_strobe;
      if ($urandom_range(0, 31) == 0) i_divider = CntW'($urandom_range(0, 5));
      reset    = ($urandom_range(0, 63) == 0);
      i_flush  = ($urandom_range(0, 15) == 0);
      i_freeze = ($urandom_range(0, 7) == 0);
      i_valid  = 1'($urandom);
      i_value  = 8'($urandom);
      step();
    end
    reset    = 1'b0;
    i_flush  = 1'b0;
    i_freeze = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
